// File: rtl/rx_symbol_align_pkg.sv
// rtl/rx_symbol_align_pkg.sv - shared comma codes and aligner state encoding
package rx_symbol_align_pkg;

    // K28.5 in both running disparities, bit 0 = first bit on the wire
    localparam logic [9:0] PCOMMA = 10'h283;
    localparam logic [9:0] NCOMMA = 10'h17C;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_CHECK    = 2'd1,
        ST_LOCKED   = 2'd2
    } align_state_e;

    function automatic logic is_comma(input logic [9:0] sym);
        return (sym == PCOMMA) || (sym == NCOMMA);
    endfunction

endpackage

// File: rtl/rx_symbol_align_if.sv
// rtl/rx_symbol_align_if.sv - lane-side bundle between the raw lane and the aligner
interface rx_symbol_align_if;
    logic [9:0] RawIn;
    logic       RxElecIdle;
    logic       DecodeErr;
    logic [9:0] LinkIn;
    logic       Synced;
    logic       CommaAligned;
    logic [3:0] AlignOffset;
    logic       SyncLost;

    modport master (
        output RawIn, RxElecIdle, DecodeErr,
        input  LinkIn, Synced, CommaAligned, AlignOffset, SyncLost
    );

    modport slave (
        input  RawIn, RxElecIdle, DecodeErr,
        output LinkIn, Synced, CommaAligned, AlignOffset, SyncLost
    );
endinterface

// File: rtl/rx_comma_find.sv
// rtl/rx_comma_find.sv - combinational comma search over a 20-bit two-word window
module rx_comma_find
    import rx_symbol_align_pkg::*;
(
    input  logic [19:0] win_i,
    output logic        any_hit_o,
    output logic [3:0]  comma_off_o
);

    // Scan high to low so the lowest matching offset is the one left standing
    always_comb begin
        any_hit_o   = 1'b0;
        comma_off_o = 4'd0;
        for (int k = 9; k >= 0; k--) begin
            if (is_comma(10'(win_i >> k))) begin
                any_hit_o   = 1'b1;
                comma_off_o = 4'(k);
            end
        end
    end

endmodule

// File: rtl/rx_symbol_align.sv
// rtl/rx_symbol_align.sv - comma aligner with lock acquisition and error-driven loss of lock
module rx_symbol_align
    import rx_symbol_align_pkg::*;
#(
    parameter int LOCK_COMMAS = 3,
    parameter int ERR_THRESH  = 4,
    parameter int GOOD_RUN    = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    rx_symbol_align_if.slave   lnk
);

    localparam logic [2:0] LOCK_N = 3'(LOCK_COMMAS);
    localparam logic [2:0] ERR_N  = 3'(ERR_THRESH);
    localparam logic [7:0] GOOD_N = 8'(GOOD_RUN);

    align_state_e state_q, state_d;
    logic [9:0]   raw_last_q;
    logic [3:0]   off_q, off_d;
    logic [2:0]   comma_cnt_q, comma_cnt_d;
    logic [2:0]   err_cnt_q, err_cnt_d;
    logic [7:0]   good_cnt_q, good_cnt_d;
    logic [9:0]   link_q, link_d;
    logic         ca_q, synced_q, lost_q, lost_d;
    logic [19:0]  win;
    logic         any_hit, err_ev;
    logic [3:0]   comma_off;

    assign win = {lnk.RawIn, raw_last_q};

    rx_comma_find u_find (
        .win_i       (win),
        .any_hit_o   (any_hit),
        .comma_off_o (comma_off)
    );

    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        comma_cnt_d = comma_cnt_q;
        err_cnt_d   = err_cnt_q;
        good_cnt_d  = good_cnt_q;
        lost_d      = 1'b0;
        err_ev      = lnk.DecodeErr || (any_hit && (comma_off != off_q));

        if ((state_q != ST_LOCKED) && any_hit) off_d = comma_off;
        link_d = 10'(win >> off_d);

        case (state_q)
            ST_UNLOCKED: begin
                if (any_hit) begin
                    if (LOCK_N == 3'd1) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d     = ST_CHECK;
                        comma_cnt_d = 3'd1;
                    end
                end
            end
            ST_CHECK: begin
                if (any_hit) begin
                    comma_cnt_d = (comma_off == off_q) ? comma_cnt_q + 3'd1 : 3'd1;
                    if (comma_cnt_d >= LOCK_N) begin
                        state_d     = ST_LOCKED;
                        comma_cnt_d = 3'd0;
                    end
                end
            end
            ST_LOCKED: begin
                // An error in the same cycle as a good-run wrap takes precedence
                if (err_ev) begin
                    err_cnt_d  = (err_cnt_q == 3'd7) ? 3'd7 : err_cnt_q + 3'd1;
                    good_cnt_d = 8'd0;
                end else if (good_cnt_q + 8'd1 == GOOD_N) begin
                    err_cnt_d  = (err_cnt_q == 3'd0) ? 3'd0 : err_cnt_q - 3'd1;
                    good_cnt_d = 8'd0;
                end else begin
                    good_cnt_d = good_cnt_q + 8'd1;
                end
                if (err_cnt_d >= ERR_N) begin
                    state_d     = ST_UNLOCKED;
                    lost_d      = 1'b1;
                    comma_cnt_d = 3'd0;
                    err_cnt_d   = 3'd0;
                    good_cnt_d  = 8'd0;
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase

        if (lnk.RxElecIdle) begin
            state_d     = ST_UNLOCKED;
            lost_d      = (state_q == ST_LOCKED);
            comma_cnt_d = 3'd0;
            err_cnt_d   = 3'd0;
            good_cnt_d  = 8'd0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_UNLOCKED;
            raw_last_q  <= 10'd0;
            off_q       <= 4'd0;
            comma_cnt_q <= 3'd0;
            err_cnt_q   <= 3'd0;
            good_cnt_q  <= 8'd0;
            link_q      <= 10'd0;
            ca_q        <= 1'b0;
            synced_q    <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            raw_last_q  <= lnk.RawIn;
            off_q       <= off_d;
            comma_cnt_q <= comma_cnt_d;
            err_cnt_q   <= err_cnt_d;
            good_cnt_q  <= good_cnt_d;
            link_q      <= link_d;
            ca_q        <= is_comma(link_d);
            synced_q    <= (state_d == ST_LOCKED);
            lost_q      <= lost_d;
        end
    end

    assign lnk.LinkIn       = link_q;
    assign lnk.Synced       = synced_q;
    assign lnk.CommaAligned = ca_q;
    assign lnk.AlignOffset  = off_q;
    assign lnk.SyncLost     = lost_q;

endmodule

// File: tb/tb_rx_symbol_align.sv
// tb/tb_rx_symbol_align.sv - scoreboard bench for rx_symbol_align against a bit-stream reference model
module tb_rx_symbol_align;
    import rx_symbol_align_pkg::*;

    localparam int LOCK = 3;
    localparam int THR  = 4;
    localparam int GOOD = 16;

    typedef struct packed {
        logic [9:0] link;
        logic       synced;
        logic       ca;
        logic [3:0] off;
        logic       lost;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    rx_symbol_align_if lnk ();

    rx_symbol_align #(.LOCK_COMMAS(LOCK), .ERR_THRESH(THR), .GOOD_RUN(GOOD)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .lnk   (lnk)
    );

    exp_t sbq[$];
    bit   bq[$];
    int   bits_total = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   obs_lost = 0;

    int         m_phase, m_off, m_cc, m_ec, m_gc;
    logic [9:0] m_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic [9:0] raw, input bit idle, input bit derr, input bit rst);
        logic [19:0] win;
        logic [9:0]  c;
        bit          any, err;
        int          coff, noff;
        exp_t        e;
        win = {raw, m_last};
        any = 0;
        coff = 0;
        for (int k = 0; k < 10; k++) begin
            c = 10'(win >> k);
            if (!any && (c == PCOMMA || c == NCOMMA)) begin
                any = 1;
                coff = k;
            end
        end
        if (rst) begin
            m_phase = 0; m_off = 0; m_cc = 0; m_ec = 0; m_gc = 0;
            e = '0;
            m_last = 10'd0;
        end else begin
            noff = (m_phase != 2 && any) ? coff : m_off;
            e.link = 10'(win >> noff);
            e.ca   = (e.link == PCOMMA) || (e.link == NCOMMA);
            e.lost = 1'b0;
            if (idle) begin
                e.lost = (m_phase == 2);
                m_phase = 0; m_cc = 0; m_ec = 0; m_gc = 0;
            end else if (m_phase == 0) begin
                if (any) begin
                    m_cc = 1;
                    m_phase = (LOCK == 1) ? 2 : 1;
                    if (m_phase == 2) m_cc = 0;
                end
            end else if (m_phase == 1) begin
                if (any) begin
                    m_cc = (coff == m_off) ? m_cc + 1 : 1;
                    if (m_cc >= LOCK) begin
                        m_phase = 2;
                        m_cc = 0;
                    end
                end
            end else begin
                err = derr || (any && coff != m_off);
                if (err) begin
                    m_ec = (m_ec < 7) ? m_ec + 1 : 7;
                    m_gc = 0;
                end else begin
                    m_gc++;
                    if (m_gc == GOOD) begin
                        m_ec = (m_ec > 0) ? m_ec - 1 : 0;
                        m_gc = 0;
                    end
                end
                if (m_ec >= THR) begin
                    e.lost = 1'b1;
                    m_phase = 0; m_cc = 0; m_ec = 0; m_gc = 0;
                end
            end
            m_off = noff;
            e.off = 4'(m_off);
            e.synced = (m_phase == 2);
            m_last = raw;
        end
        sbq.push_back(e);
    endtask

    task automatic send(input logic [9:0] w, input bit idle, input bit derr, input bit rst);
        @(negedge Clk);
        lnk.RawIn      = w;
        lnk.RxElecIdle = idle;
        lnk.DecodeErr  = derr;
        Reset          = rst;
        model_step(w, idle, derr, rst);
    endtask

    // Filler never runs more than three equal bits, so commas only appear where placed
    task automatic add_fill(input int n);
        bit b;
        for (int i = 0; i < n; i++) begin
            b = bit'($urandom % 2);
            if (bq.size() >= 3 && bq[$] == bq[$-1] && bq[$-1] == bq[$-2]) b = ~bq[$];
            bq.push_back(b);
            bits_total++;
        end
    endtask

    task automatic add_comma(input int off, input bit neg);
        logic [9:0] cw;
        while (bits_total % 10 != off) add_fill(1);
        cw = neg ? NCOMMA : PCOMMA;
        for (int i = 0; i < 10; i++) begin
            bq.push_back(cw[i]);
            bits_total++;
        end
    endtask

    task automatic pop_word(output logic [9:0] w);
        for (int i = 0; i < 10; i++) w[i] = bq.pop_front();
    endtask

    task automatic pump(input int n, input bit idle, input bit derr);
        logic [9:0] w;
        while (bq.size() < 10 * n) add_fill(1);
        for (int i = 0; i < n; i++) begin
            pop_word(w);
            send(w, idle, derr, 1'b0);
        end
    endtask

    task automatic pump_all();
        while (bq.size() >= 10) pump(1, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) send(10'($urandom), 1'b0, 1'b0, 1'b1);
    endtask

    task automatic settle();
        @(posedge Clk);
        #2;
    endtask

    task automatic lock_at(input int off);
        for (int i = 0; i < LOCK; i++) begin
            add_comma(off, bit'($urandom % 2));
            add_fill(10 * $urandom_range(3, 12));
        end
        pump_all();
        settle();
        check("lock_synced", 32'(lnk.Synced), 32'd1);
        check("lock_offset", 32'(lnk.AlignOffset), 32'(off));
    endtask

    initial begin : monitor
        exp_t e, a;
        forever begin
            @(posedge Clk);
            #1;
            if (lnk.SyncLost === 1'b1) obs_lost++;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                a = {lnk.LinkIn, lnk.Synced, lnk.CommaAligned, lnk.AlignOffset, lnk.SyncLost};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t got link=%h sync=%b ca=%b off=%0d lost=%b expected link=%h sync=%b ca=%b off=%0d lost=%b",
                             $time, a.link, a.synced, a.ca, a.off, a.lost, e.link, e.synced, e.ca, e.off, e.lost);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int lost0, fav;
        lnk.RawIn = 10'd0;
        lnk.RxElecIdle = 1'b0;
        lnk.DecodeErr = 1'b0;
        Reset = 1'b1;
        m_phase = 0; m_off = 0; m_cc = 0; m_ec = 0; m_gc = 0; m_last = 10'd0;

        do_reset(3);
        settle();
        check("reset_synced", 32'(lnk.Synced), 32'd0);
        check("reset_link", 32'(lnk.LinkIn), 32'd0);

        // Three commas at offset 3, 16 words apart
        for (int i = 0; i < 3; i++) begin
            add_comma(3, bit'(i % 2));
            add_fill(150);
        end
        pump_all();
        settle();
        check("off3_synced", 32'(lnk.Synced), 32'd1);
        check("off3_offset", 32'(lnk.AlignOffset), 32'd3);

        // Offset change restarts the count
        do_reset(2);
        add_comma(3, 0); add_fill(60);
        add_comma(3, 1); add_fill(60);
        add_comma(7, 0); add_fill(60);
        add_comma(7, 1); add_fill(60);
        pump_all();
        settle();
        check("restart_not_synced", 32'(lnk.Synced), 32'd0);
        lock_at(7);

        // Four decode errors spaced by five good symbols drop lock once
        lost0 = obs_lost;
        for (int i = 0; i < 4; i++) begin
            pump(1, 1'b0, 1'b1);
            if (i < 3) pump(5, 1'b0, 1'b0);
        end
        pump(2, 1'b0, 1'b0);
        settle();
        check("errs_lost_once", 32'(obs_lost - lost0), 32'd1);
        check("errs_unsynced", 32'(lnk.Synced), 32'd0);

        // Error count decays over good runs
        lock_at(7);
        pump(3, 1'b0, 1'b1);
        pump(48, 1'b0, 1'b0);
        pump(3, 1'b0, 1'b1);
        pump(1, 1'b0, 1'b0);
        settle();
        check("decay_still_synced", 32'(lnk.Synced), 32'd1);

        // Error on the cycle the good run would wrap: error wins
        do_reset(2);
        lock_at(5);
        pump(1, 1'b0, 1'b1);
        pump(15, 1'b0, 1'b0);
        pump(1, 1'b0, 1'b1);
        settle();
        check("wrap_err_synced", 32'(lnk.Synced), 32'd1);
        pump(2, 1'b0, 1'b1);
        pump(1, 1'b0, 1'b0);
        settle();
        check("wrap_err_dropped", 32'(lnk.Synced), 32'd0);

        // Electrical idle while locked
        lock_at(2);
        lost0 = obs_lost;
        pump(1, 1'b1, 1'b0);
        pump(2, 1'b0, 1'b0);
        settle();
        check("idle_lost", 32'(obs_lost - lost0), 32'd1);
        check("idle_unsynced", 32'(lnk.Synced), 32'd0);

        // Reset while locked: no loss pulse
        lock_at(2);
        lost0 = obs_lost;
        do_reset(2);
        settle();
        check("rst_no_lost", 32'(obs_lost - lost0), 32'd0);
        check("rst_offset", 32'(lnk.AlignOffset), 32'd0);
        pump(1, 1'b0, 1'b0);

        // Randomised traffic
        fav = 4;
        for (int it = 0; it < 70; it++) begin
            logic [9:0] w;
            int r;
            r = $urandom % 10;
            if (r < 6) add_comma(fav, bit'($urandom % 2));
            else if (r < 8) add_comma($urandom % 10, bit'($urandom % 2));
            else if (r == 8) fav = $urandom % 10;
            add_fill($urandom_range(20, 200));
            while (bq.size() >= 10) begin
                pop_word(w);
                send(w, ($urandom % 60) == 0, ($urandom % 15) == 0, ($urandom % 300) == 0);
            end
            if ($urandom % 8 == 0)
                for (int j = 0; j < 3; j++) send(10'($urandom), 1'b0, ($urandom % 4) == 0, 1'b0);
        end

        repeat (3) @(negedge Clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
